// File: rtl/rr_mux4_stream_if.sv
// rr_mux4_stream_if: four valid/ready input channels merged into one tagged output stream
interface rr_mux4_stream_if #(parameter int WIDTH = 8);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_last;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [1:0]         out_sel;
  logic               out_ready;
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/rr_mux4_stream.sv
// rr_mux4_stream: 4:1 round-robin stream merge with packet locking and a registered output
module rr_mux4_stream #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  rr_mux4_stream_if.slave  bus
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t     state;
  logic [1:0] ptr;
  logic [1:0] lock_ch;
  logic [1:0] g;
  logic       gv;
  logic       load_ok;
  logic       xfer;
  assign load_ok = !bus.out_valid | bus.out_ready;
  always_comb begin
    g  = lock_ch;
    gv = state == LOCKED;
    if (state == IDLE)
      for (int k = 3; k >= 0; k--)
        if (bus.in_valid[ptr + 2'(k)]) begin
          g  = ptr + 2'(k);
          gv = 1'b1;
        end
  end
  // ready never looks at data/last, only at valid and the output register
  assign bus.in_ready = (gv && load_ok && !rst) ? 4'b0001 << g : 4'b0000;
  assign xfer = |(bus.in_valid & bus.in_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      lock_ch       <= 2'd0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_sel   <= 2'd0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(g)*WIDTH +: WIDTH];
      bus.out_last  <= bus.in_last[g];
      bus.out_sel   <= g;
      state         <= bus.in_last[g] ? IDLE : LOCKED;
      lock_ch       <= g;
      ptr           <= bus.in_last[g] ? g + 2'd1 : ptr;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux4_stream.sv
// tb_rr_mux4_stream: scenario tasks drive channels; a scoreboard queue checks every output beat in order
module tb_rr_mux4_stream;
  typedef struct packed {
    logic [1:0] sel;
    logic       last;
    logic [7:0] data;
  } beat_t;
  logic clk;
  logic rst;
  int errors;
  int checks;
  beat_t exp_q[$];
  rr_mux4_stream_if #(.WIDTH(8)) bus ();
  rr_mux4_stream #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic beat_t mk(input logic [1:0] s, input logic l, input logic [7:0] d);
    beat_t b;
    b.sel  = s;
    b.last = l;
    b.data = d;
    return b;
  endfunction
  // one clock: score any output transfer, report input transfers, return at posedge+1
  task automatic cycle(output logic [3:0] x);
    beat_t e;
    @(negedge clk);
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got unexpected sel=%0d last=%0b data=%h, required no beat", bus.out_sel, bus.out_last, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_sel, bus.out_last, bus.out_data} !== e) begin
          errors++;
          $display("FAIL beat: got sel=%0d last=%0b data=%h, required sel=%0d last=%0b data=%h", bus.out_sel, bus.out_last, bus.out_data, e.sel, e.last, e.data);
        end
      end
    end
    x = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    logic [3:0] x;
    int k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      cycle(x);
      k++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_last = 4'b1111;
    for (int i = 0; i < 4; i++) bus.in_data[i*8 +: 8] = 8'hA0 + 8'(i);
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    if (bus.out_sel !== 2'd0) begin errors++; $display("FAIL reset_out_sel: got %0d, required 0", bus.out_sel); end
    if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h, required 00", bus.out_data); end
    if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b, required 0000", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant: got in_ready=%b, required 0001", bus.in_ready); end
    bus.in_valid = 4'b0000;
  endtask
  task automatic test_round_robin();
    logic [3:0] x;
    int n = 0;
    int c = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(2'(i % 4), 1'b1, 8'hA0 + 8'(i % 4)));
    bus.in_valid = 4'b1111;
    while (n < 8 && c < 20) begin
      cycle(x);
      c++;
      n += $countones(x);
    end
    bus.in_valid = 4'b0000;
    checks++;
    if (c !== 8) begin errors++; $display("FAIL rr_no_bubble: got %0d cycles for 8 beats, required 8", c); end
    drain();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rr_drain: got %0d beats missing, required 0", exp_q.size()); end
  endtask
  task automatic test_packet_lock();
    logic [3:0] x;
    int n = 0;
    int c = 0;
    int b = 0;
    exp_q.push_back(mk(2'd2, 1'b0, 8'h20));
    exp_q.push_back(mk(2'd2, 1'b0, 8'h21));
    exp_q.push_back(mk(2'd2, 1'b1, 8'h22));
    exp_q.push_back(mk(2'd3, 1'b1, 8'h13));
    exp_q.push_back(mk(2'd0, 1'b1, 8'h10));
    exp_q.push_back(mk(2'd1, 1'b1, 8'h11));
    bus.in_data = {8'h13, 8'h20, 8'h11, 8'h10};
    bus.in_last = 4'b1011;
    bus.in_valid = 4'b0100;
    while (n < 6 && c < 20) begin
      cycle(x);
      c++;
      n += $countones(x);
      if (x[2]) b++;
      bus.in_data[23:16] = 8'h20 + 8'(b);
      bus.in_last[2] = b == 2;
      bus.in_valid = {1'b1, b < 3, 2'b11};
      if (c == 1) begin
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready: got %b, required 0100", bus.in_ready); end
      end
    end
    bus.in_valid = 4'b0000;
    drain();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL lock_drain: got %0d beats missing, required 0", exp_q.size()); end
  endtask
  task automatic test_backpressure();
    logic [3:0] x;
    int c = 0;
    exp_q.push_back(mk(2'd1, 1'b1, 8'h5C));
    exp_q.push_back(mk(2'd1, 1'b1, 8'h5D));
    bus.in_last = 4'b1111;
    bus.in_data[15:8] = 8'h5C;
    bus.in_valid = 4'b0010;
    bus.out_ready = 1'b1;
    cycle(x);
    bus.in_data[15:8] = 8'h5D;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(x);
      checks += 3;
      if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready: got %b, required 0000", bus.in_ready); end
      if (bus.out_data !== 8'h5C) begin errors++; $display("FAIL stall_data: got %h, required 5c", bus.out_data); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, required 1", bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    x = 4'b0000;
    while (!x[1] && c < 10) begin
      cycle(x);
      c++;
    end
    bus.in_valid = 4'b0000;
    drain();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_drain: got %0d beats missing, required 0", exp_q.size()); end
  endtask
  task automatic test_lock_gap();
    logic [3:0] x;
    int n = 0;
    int c = 0;
    exp_q.push_back(mk(2'd0, 1'b0, 8'h30));
    bus.in_data[7:0] = 8'h30;
    bus.in_last = 4'b1110;
    bus.in_valid = 4'b0001;
    cycle(x);
    bus.in_data[15:8] = 8'h40;
    bus.in_valid = 4'b0010;
    repeat (2) cycle(x);
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid: got %b, required 0", bus.out_valid); end
    if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL gap_ready: got %b, required 0001", bus.in_ready); end
    exp_q.push_back(mk(2'd0, 1'b1, 8'h31));
    exp_q.push_back(mk(2'd1, 1'b1, 8'h40));
    bus.in_data[7:0] = 8'h31;
    bus.in_last = 4'b1111;
    bus.in_valid = 4'b0011;
    while (n < 2 && c < 10) begin
      cycle(x);
      c++;
      n += $countones(x);
      bus.in_valid = bus.in_valid & ~x;
    end
    bus.in_valid = 4'b0000;
    drain();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL gap_drain: got %0d beats missing, required 0", exp_q.size()); end
  endtask
  task automatic test_reset_mid_packet();
    logic [3:0] x;
    int n = 0;
    int c = 0;
    bus.in_data[31:24] = 8'h50;
    bus.in_last = 4'b0000;
    bus.in_valid = 4'b1000;
    bus.out_ready = 1'b0;
    cycle(x);
    // beat 0x50 is still held in the output register and is dropped by reset
    bus.in_data[31:24] = 8'h51;
    rst = 1'b1;
    cycle(x);
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0", bus.out_valid); end
    if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b, required 0000", bus.in_ready); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data[15:8] = 8'h61;
    bus.in_data[31:24] = 8'h63;
    bus.in_last = 4'b1111;
    bus.in_valid = 4'b1010;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL post_reset_grant: got %b, required 0010", bus.in_ready); end
    exp_q.push_back(mk(2'd1, 1'b1, 8'h61));
    exp_q.push_back(mk(2'd3, 1'b1, 8'h63));
    while (n < 2 && c < 10) begin
      cycle(x);
      c++;
      n += $countones(x);
      bus.in_valid = bus.in_valid & ~x;
    end
    bus.in_valid = 4'b0000;
    drain();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_drain: got %0d beats missing, required 0", exp_q.size()); end
  endtask
  initial begin
    errors = 0;
    checks = 0;
    bus.in_valid = 4'b0000;
    bus.in_last = 4'b0000;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_lock_gap();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
